// File: rtl/simbacore_csr_pkg.sv
// Shared types and constants for the SimbaCore CSR front-end.
// Word indices, status bit positions, FSM states and config bundle.
package simbacore_csr_pkg;

    localparam int unsigned CFG_MODE_W = 2;
    localparam int unsigned CFG_DATA_W = 32;

    localparam int unsigned CSR_MODE   = 0;
    localparam int unsigned CSR_SEQLEN = 1;
    localparam int unsigned CSR_DMODEL = 2;
    localparam int unsigned CSR_DTRANK = 3;
    localparam int unsigned CSR_DINNER = 4;
    localparam int unsigned CSR_DFINAL = 5;

    localparam int unsigned RO_STATUS = 0;
    localparam int unsigned RO_CYCLES = 1;
    localparam int unsigned RO_LAUNCH = 2;
    localparam int unsigned RO_ERRCNT = 3;

    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_ACTIVE = 1;
    localparam int unsigned STAT_ERR    = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        RUN       = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic [CFG_MODE_W-1:0] mode;
        logic [CFG_DATA_W-1:0] seq_len;
        logic [CFG_DATA_W-1:0] d_model;
        logic [CFG_DATA_W-1:0] dt_rank;
        logic [CFG_DATA_W-1:0] d_inner;
        logic [CFG_DATA_W-1:0] d_final;
    } cfg_t;

endpackage

// File: rtl/snax_simbacore_sat_counter.sv
// Up-counter with synchronous clear and selectable saturate/wrap.
// Clear takes priority over enable.
module snax_simbacore_sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             sat_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !(sat_i && (&cnt_q))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/snax_simbacore_csr_ctrl.sv
// SimbaCore config front-end: latches and checks a CSR set, issues it
// to the core, tracks one run and reports status via RO CSRs.
module snax_simbacore_csr_ctrl
    import simbacore_csr_pkg::*;
#(
    parameter int unsigned RegRWCount   = 6,
    parameter int unsigned RegROCount   = 4,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned ModeWidth    = 2,
    parameter int unsigned NumModes     = 3,
    parameter int unsigned StartTimeout = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [RegRWCount*RegDataWidth-1:0]   csr_reg_set_i,
    input  logic                                 csr_reg_set_valid_i,
    output logic                                 csr_reg_set_ready_o,
    output logic [RegROCount*RegDataWidth-1:0]   csr_reg_ro_set_o,
    output logic                                 cfg_valid_o,
    input  logic                                 cfg_ready_i,
    output logic [ModeWidth-1:0]                 cfg_mode_o,
    output logic [RegDataWidth-1:0]              cfg_seq_len_o,
    output logic [RegDataWidth-1:0]              cfg_d_model_o,
    output logic [RegDataWidth-1:0]              cfg_dt_rank_o,
    output logic [RegDataWidth-1:0]              cfg_d_inner_o,
    output logic [RegDataWidth-1:0]              cfg_d_final_o,
    input  logic                                 core_busy_i,
    output logic                                 done_o
);

    localparam int unsigned TimerWidth = $clog2(StartTimeout);
    localparam logic [TimerWidth-1:0] TimeoutLast = TimerWidth'(StartTimeout - 1);

    ctrl_state_e            state_q, state_d;
    cfg_t                   cfg_q, cfg_d;
    logic                   cfg_valid_q, cfg_valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [TimerWidth-1:0]  timer_q, timer_d;

    logic                   set_ready;
    logic                   cyc_clr, cyc_en, launch_en, err_inc;
    logic [RegDataWidth-1:0] cycle_cnt, launch_cnt, err_cnt;

    logic [RegDataWidth-1:0] mode_w, seq_len_w, d_model_w;
    logic [RegDataWidth-1:0] dt_rank_w, d_inner_w, d_final_w;
    logic                    set_legal;

    assign mode_w    = csr_reg_set_i[CSR_MODE*RegDataWidth +: RegDataWidth];
    assign seq_len_w = csr_reg_set_i[CSR_SEQLEN*RegDataWidth +: RegDataWidth];
    assign d_model_w = csr_reg_set_i[CSR_DMODEL*RegDataWidth +: RegDataWidth];
    assign dt_rank_w = csr_reg_set_i[CSR_DTRANK*RegDataWidth +: RegDataWidth];
    assign d_inner_w = csr_reg_set_i[CSR_DINNER*RegDataWidth +: RegDataWidth];
    assign d_final_w = csr_reg_set_i[CSR_DFINAL*RegDataWidth +: RegDataWidth];

    // Full-word mode compare so out-of-range values never alias into the field
    assign set_legal = (mode_w < RegDataWidth'(NumModes)) && (seq_len_w != '0);

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        timer_d     = timer_q;
        set_ready   = 1'b0;
        cyc_clr     = 1'b0;
        cyc_en      = 1'b0;
        launch_en   = 1'b0;
        err_inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                set_ready = 1'b1;
                if (csr_reg_set_valid_i) begin
                    if (set_legal) begin
                        cfg_d.mode    = mode_w[CFG_MODE_W-1:0];
                        cfg_d.seq_len = seq_len_w;
                        cfg_d.d_model = d_model_w;
                        cfg_d.dt_rank = dt_rank_w;
                        cfg_d.d_inner = d_inner_w;
                        cfg_d.d_final = d_final_w;
                        err_d         = 1'b0;
                        cfg_valid_d   = 1'b1;
                        state_d       = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cfg_ready_i) begin
                    cfg_valid_d = 1'b0;
                    launch_en   = 1'b1;
                    cyc_clr     = 1'b1;
                    timer_d     = '0;
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                cyc_en = 1'b1;
                if (core_busy_i) begin
                    state_d = RUN;
                end else if (timer_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    err_inc = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN: begin
                cyc_en = 1'b1;
                if (!core_busy_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
        end
    end

    snax_simbacore_sat_counter #(.Width(RegDataWidth)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cyc_clr),
        .en_i  (cyc_en),
        .sat_i (1'b1),
        .cnt_o (cycle_cnt)
    );

    snax_simbacore_sat_counter #(.Width(RegDataWidth)) u_launch_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (launch_en),
        .sat_i (1'b0),
        .cnt_o (launch_cnt)
    );

    snax_simbacore_sat_counter #(.Width(RegDataWidth)) u_err_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (err_inc),
        .sat_i (1'b1),
        .cnt_o (err_cnt)
    );

    always_comb begin
        csr_reg_ro_set_o = '0;
        csr_reg_ro_set_o[RO_STATUS*RegDataWidth + STAT_BUSY]   = core_busy_i;
        csr_reg_ro_set_o[RO_STATUS*RegDataWidth + STAT_ACTIVE] = (state_q != IDLE);
        csr_reg_ro_set_o[RO_STATUS*RegDataWidth + STAT_ERR]    = err_q;
        csr_reg_ro_set_o[RO_CYCLES*RegDataWidth +: RegDataWidth] = cycle_cnt;
        csr_reg_ro_set_o[RO_LAUNCH*RegDataWidth +: RegDataWidth] = launch_cnt;
        csr_reg_ro_set_o[RO_ERRCNT*RegDataWidth +: RegDataWidth] = err_cnt;
    end

    assign csr_reg_set_ready_o = set_ready;
    assign cfg_valid_o   = cfg_valid_q;
    assign cfg_mode_o    = ModeWidth'(cfg_q.mode);
    assign cfg_seq_len_o = cfg_q.seq_len;
    assign cfg_d_model_o = cfg_q.d_model;
    assign cfg_dt_rank_o = cfg_q.dt_rank;
    assign cfg_d_inner_o = cfg_q.d_inner;
    assign cfg_d_final_o = cfg_q.d_final;
    assign done_o        = done_q;

endmodule

// File: doc/snax_simbacore_csr_ctrl.md
Name: snax_simbacore_csr_ctrl

Overview:
Configuration front-end between the SNAX CSR manager and the SimbaCore accelerator config port. It latches a CSR register set, checks it for legality, and issues it to the core with a valid/ready handshake. It then tracks the core busy flag through one run, counts cycles and launches, and exposes status through the read-only CSR set.

Parameters:
RegRWCount, 6, number of RW CSR words: mode, seqLen, dModel, dtRank, dInner, dFinal.
RegROCount, 4, number of RO CSR words.
RegDataWidth, 32, CSR word width.
ModeWidth, 2, width of the mode field.
NumModes, 3, legal modes are 0..NumModes-1.
StartTimeout, 16, cycles allowed after a config handshake for core_busy_i to rise.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
csr_reg_set_i  in  RegRWCount*RegDataWidth  RW CSR words; word k at [k*32 +: 32]
csr_reg_set_valid_i  in  1  CSR set valid
csr_reg_set_ready_o  out  1  CSR set accepted
csr_reg_ro_set_o  out  RegROCount*RegDataWidth  RO CSR words
cfg_valid_o  out  1  config valid to core
cfg_ready_i  in  1  core accepts config
cfg_mode_o  out  ModeWidth  latched mode
cfg_seq_len_o, cfg_d_model_o, cfg_dt_rank_o, cfg_d_inner_o, cfg_d_final_o  out  32 each  latched dimensions
core_busy_i  in  1  core busy flag
done_o  out  1  one-cycle pulse when a run completes or aborts

Behaviour:
- One clock domain, clk_i. Reset rst_i is asynchronous and active-high; all flops clear immediately on assertion.
- Reset values: FSM in IDLE, csr_reg_set_ready_o=1, cfg_valid_o=0, all cfg_* data outputs 0, done_o=0, all counters 0, sticky error 0.
- FSM states: IDLE, ISSUE, WAIT_BUSY, RUN.
- IDLE:
  - csr_reg_set_ready_o=1 combinationally. It is 0 in every other state.
  - On a valid&ready handshake, check legality: mode < NumModes and seqLen != 0.
  - Illegal set: no latch, set the sticky error, err_cnt += 1, stay in IDLE.
  - Legal set: latch all words into the cfg_* registers, clear the sticky error, go to ISSUE on the next cycle.
- ISSUE:
  - cfg_valid_o=1 from a register. cfg_* outputs are stable while valid is high.
  - On cfg_ready_i=1: launch_cnt += 1 (wraps at 2^32), cycle_cnt clears to 0, go to WAIT_BUSY.
  - Stalling on cfg_ready_i=0 has no limit.
- WAIT_BUSY:
  - A timer counts from 0. cycle_cnt increments every cycle.
  - core_busy_i=1: go to RUN.
  - Timer reaches StartTimeout-1 with core_busy_i still 0: set the sticky error, err_cnt += 1, pulse done_o, go to IDLE.
- RUN:
  - cycle_cnt increments every cycle and saturates at 2^32-1.
  - core_busy_i=0: pulse done_o for exactly one cycle (the cycle after the sample), go to IDLE.
  - cycle_cnt then holds its value until the next successful launch.
- Simultaneous events:
  - A valid CSR set arriving in the same cycle as done_o is accepted only once IDLE is reached (ready is low in RUN).
  - A handshake in IDLE and an illegal-set error never coincide with a timeout.
- Reset asserted mid-run: everything returns to reset values. The core is not notified; its own reset is tied to the same source.
- RO map:
  - word0 = {29'b0, sticky_err, (state!=IDLE), core_busy_i}
  - word1 = cycle_cnt
  - word2 = launch_cnt
  - word3 = err_cnt (saturating)
- Latency: legal CSR handshake to cfg_valid_o=1 is 1 cycle. Core busy falling to done_o is 1 cycle.

Decomposition:
- Shared package simbacore_csr_pkg holds:
  - state enum ctrl_state_e
  - word index constants CSR_MODE..CSR_DFINAL and RO_STATUS..RO_ERRCNT
  - status bit positions
  - a typedef for the config struct {mode, seqLen, dModel, dtRank, dInner, dFinal}
- One sub-module: snax_simbacore_sat_counter (parameterised width, clear, enable, saturate/wrap select). It is used for cycle_cnt, err_cnt and launch_cnt.

Test Plan:
1. Reset, then a legal set (mode=1, seqLen=64, dModel=128, dtRank=8, dInner=256, dFinal=32); cfg_ready_i high; core_busy_i high for 10 cycles -> cfg_valid_o rises 1 cycle after the handshake and carries the exact values; done_o pulses once; word1=cycle count of that run; word2=1; word0 error bit=0.
2. Set with mode=3 (NumModes=3) -> accepted in the same cycle, no cfg_valid_o, word0 bit2=1, word3=1, FSM stays IDLE. A following legal set clears bit2.
3. Set with seqLen=0 -> rejected as in 2; word3 increments to 2.
4. Legal set, cfg_ready_i held low 20 cycles then high -> cfg_valid_o high for 21 cycles, cfg_* stable throughout, csr_reg_set_ready_o=0 throughout.
5. Legal set, core_busy_i never asserted -> done_o pulses StartTimeout cycles after the config handshake; word0 bit2=1; word3 increments; word2 still increments (launch counted).
6. rst_i asserted asynchronously mid-RUN (between clock edges) -> all outputs drop to reset values before the next edge; the next legal set runs normally with word2=1.
